sel_split_n: RTL and testbench

- Clocked, parametrised N-way conditional token split for the stream-instruction control path.
- Upstream sends one token (i_drive) plus a select mask (i_valid). The block forwards the token to the selected downstream channel(s) and returns o_free to upstream once the token has been dispatched.
- Each output keeps a credit counter sized to the downstream buffer depth, replenished by i_freeNext. This is the successor to the fixed 5-way split.
- Generalised in channel count and credit depth, with an optional multicast mode.

---
 rtl/sel_split_n.sv | 163 ++++++++++++++++
 tb/tb_sel_split_n.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sel_split_n.sv
// sel_split_n: N-way conditional token split with per-output credits.
// Ports: clk, rst (async, active low), i_drive/i_valid token in,
//   o_free ack out, o_driveNext/i_freeNext per-channel token/credit,
//   o_busy token held, o_credit packed counts (CW bits per channel),
//   o_err [2:0] sticky errors only when SEL_SPLIT_N_ERR_EN is defined.
module sel_split_n #(
  parameter int N = 5,
  parameter int CREDITS = 1,
  parameter int MULTICAST = 0,
  localparam int CW = $clog2(CREDITS + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_drive,
  input  logic [N-1:0]    i_valid,
  output logic            o_free,
  output logic [N-1:0]    o_driveNext,
  input  logic [N-1:0]    i_freeNext,
  output logic            o_busy,
  output logic [N*CW-1:0] o_credit
`ifdef SEL_SPLIT_N_ERR_EN
  ,
  output logic [2:0]      o_err
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    ACK
  } state_t;

  localparam logic [CW-1:0] CMAX = CW'(CREDITS);

  state_t        r_state;
  logic [N-1:0]  r_mask;
  logic [N-1:0]  r_drv;
  logic          r_free;
  logic          r_busy;
  logic [CW-1:0] r_cred [N];

  logic [N-1:0]  w_low;
  logic [N-1:0]  w_eff;
  logic          w_accept;
  logic          w_ready;
  logic          w_disp;

  // Isolate the lowest set bit for unicast.
  assign w_low = i_valid & (~i_valid + {{(N-1){1'b0}}, 1'b1});
  assign w_eff = (MULTICAST != 0) ? i_valid : w_low;

  // A drive arriving with o_free is dropped.
  assign w_accept = (r_state == IDLE) && i_drive && !r_free;

  // Every targeted channel needs a registered credit.
  always_comb begin
    w_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (r_mask[k] && (r_cred[k] == '0)) begin
        w_ready = 1'b0;
      end
    end
  end

  assign w_disp = (r_state == HOLD) && w_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_mask  <= '0;
      r_drv   <= '0;
      r_free  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_drv  <= '0;
      r_free <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_mask  <= w_eff;
            r_busy  <= 1'b1;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (w_ready) begin
            r_drv   <= r_mask;
            r_state <= ACK;
          end
        end
        ACK: begin
          r_free  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_cred
    logic w_d;
    logic w_f;
    assign w_d = w_disp & r_mask[k];
    assign w_f = i_freeNext[k];

    // Return and dispatch together cancel out.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_cred[k] <= CMAX;
      end else if (w_f && !w_d) begin
        if (r_cred[k] != CMAX) begin
          r_cred[k] <= r_cred[k] + 1'b1;
        end
      end else if (w_d && !w_f) begin
        r_cred[k] <= r_cred[k] - 1'b1;
      end
    end

    assign o_credit[k*CW +: CW] = r_cred[k];
  end

  assign o_free      = r_free;
  assign o_driveNext = r_drv;
  assign o_busy      = r_busy;

`ifdef SEL_SPLIT_N_ERR_EN
  logic [2:0] r_err;
  logic       w_ovf;
  logic       w_bad;
  logic       w_multi;

  always_comb begin
    w_ovf = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (i_freeNext[k] && !(w_disp && r_mask[k]) &&
          (r_cred[k] == CMAX)) begin
        w_ovf = 1'b1;
      end
    end
  end

  assign w_multi = |(i_valid & (i_valid - {{(N-1){1'b0}}, 1'b1}));
  assign w_bad   = (i_valid == '0) ||
                   ((MULTICAST == 0) && w_multi);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= '0;
    end else begin
      if (i_drive && ((r_state != IDLE) || r_free)) r_err[0] <= 1'b1;
      if (w_ovf) r_err[1] <= 1'b1;
      if (w_accept && w_bad) r_err[2] <= 1'b1;
    end
  end

  assign o_err = r_err;
`endif

endmodule

// File: tb/tb_sel_split_n.sv
// tb_sel_split_n: bench for sel_split_n, unicast (CREDITS=2)
// and multicast (CREDITS=1) instances against a token-level model.
module tb_sel_split_n;

  logic       clk;
  logic       rst;
  logic       i_drive;
  logic [4:0] i_valid;
  logic [4:0] i_freeNext;

  logic       a_free, b_free;
  logic [4:0] a_drv, b_drv;
  logic       a_busy, b_busy;
  logic [9:0] a_cred;
  logic [4:0] b_cred;
`ifdef SEL_SPLIT_N_ERR_EN
  logic [2:0] a_err, b_err;
`endif

  int total = 0;
  int bad = 0;

  sel_split_n #(.N(5), .CREDITS(2), .MULTICAST(0)) u_a (
    .clk(clk), .rst(rst), .i_drive(i_drive), .i_valid(i_valid),
    .o_free(a_free), .o_driveNext(a_drv), .i_freeNext(i_freeNext),
    .o_busy(a_busy), .o_credit(a_cred)
`ifdef SEL_SPLIT_N_ERR_EN
    , .o_err(a_err)
`endif
  );

  sel_split_n #(.N(5), .CREDITS(1), .MULTICAST(1)) u_b (
    .clk(clk), .rst(rst), .i_drive(i_drive), .i_valid(i_valid),
    .o_free(b_free), .o_driveNext(b_drv), .i_freeNext(i_freeNext),
    .o_busy(b_busy), .o_credit(b_cred)
`ifdef SEL_SPLIT_N_ERR_EN
    , .o_err(b_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Token-level reference: one held token per instance, its
  // dispatch gated by credits, acknowledged one cycle later.
  int         CRED [2] = '{2, 1};
  bit         MC   [2] = '{1'b0, 1'b1};
  int         cr   [2][5];
  bit         have [2];
  bit         sent [2];
  logic [4:0] tmask[2];
  logic [4:0] edrv [2];
  bit         efree[2];
  logic [2:0] eerr [2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 5; k++) cr[d][k] = CRED[d];
      have[d] = 0; sent[d] = 0; tmask[d] = '0;
      edrv[d] = '0; efree[d] = 0; eerr[d] = '0;
    end
  endtask

  task automatic model_step(input int d);
    bit disp, fin, acc;
    int cnt;
    disp = have[d] && !sent[d];
    for (int k = 0; k < 5; k++)
      if (disp && tmask[d][k] && cr[d][k] == 0) disp = 0;
    for (int k = 0; k < 5; k++) begin
      bit dk, fk;
      dk = disp && tmask[d][k];
      fk = i_freeNext[k];
      if (fk && !dk) begin
        if (cr[d][k] == CRED[d]) eerr[d][1] = 1;
        else cr[d][k]++;
      end else if (dk && !fk) begin
        cr[d][k]--;
      end
    end
    if (i_drive && (have[d] || efree[d])) eerr[d][0] = 1;
    acc = !have[d] && !efree[d] && i_drive;
    fin = have[d] && sent[d];
    edrv[d] = disp ? tmask[d] : 5'b0;
    if (disp) sent[d] = 1;
    if (fin) begin have[d] = 0; sent[d] = 0; end
    if (acc) begin
      cnt = 0;
      for (int k = 0; k < 5; k++) if (i_valid[k]) cnt++;
      have[d] = 1; sent[d] = 0;
      if (MC[d]) begin
        tmask[d] = i_valid;
      end else begin
        tmask[d] = '0;
        for (int k = 4; k >= 0; k--)
          if (i_valid[k]) tmask[d] = 5'b1 << k;
      end
      if (cnt == 0 || (!MC[d] && cnt > 1)) eerr[d][2] = 1;
    end
    efree[d] = fin;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a_free", 32'(a_free), 32'(efree[0]));
    chk("a_drv", 32'(a_drv), 32'(edrv[0]));
    chk("a_busy", 32'(a_busy), 32'(have[0]));
    chk("b_free", 32'(b_free), 32'(efree[1]));
    chk("b_drv", 32'(b_drv), 32'(edrv[1]));
    chk("b_busy", 32'(b_busy), 32'(have[1]));
    for (int k = 0; k < 5; k++) begin
      chk("a_cred", 32'(a_cred[k*2 +: 2]), 32'(cr[0][k]));
      chk("b_cred", 32'(b_cred[k]), 32'(cr[1][k]));
    end
`ifdef SEL_SPLIT_N_ERR_EN
    chk("a_err", 32'(a_err), 32'(eerr[0]));
    chk("b_err", 32'(b_err), 32'(eerr[1]));
`endif
  endtask

  task automatic cyc(input logic d, input logic [4:0] v,
                     input logic [4:0] f);
    i_drive = d; i_valid = v; i_freeNext = f;
    model_step(0);
    model_step(1);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 5'b0, 5'b0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_a_free", 32'(a_free), 0);
    chk("rst_a_drv", 32'(a_drv), 0);
    chk("rst_a_busy", 32'(a_busy), 0);
    chk("rst_a_cred", 32'(a_cred), 32'h2AA);
    chk("rst_b_busy", 32'(b_busy), 0);
    chk("rst_b_cred", 32'(b_cred), 32'h1F);
  endtask

  task automatic do_reset();
    i_drive = 0; i_valid = '0; i_freeNext = '0;
    #2 rst = 1'b0;
    #1 check_reset_outputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic first_token();
    cyc(1'b1, 5'b00100, 5'b0);
    cyc(1'b0, 5'b0, 5'b0);
    chk("t2_a_drv", 32'(a_drv), 32'h04);
    chk("t2_b_drv", 32'(b_drv), 32'h04);
    cyc(1'b0, 5'b0, 5'b0);
    chk("t3_a_free", 32'(a_free), 1);
    chk("t3_a_cred2", 32'(a_cred[5:4]), 1);
    chk("t3_b_cred2", 32'(b_cred[2]), 0);
  endtask

  initial begin
    rst = 1'b0;
    i_drive = 0; i_valid = '0; i_freeNext = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs();
    rst = 1'b1;

    first_token();
    idle(2);

    // Credit exhaustion on the CREDITS=1 instance.
    cyc(1'b1, 5'b00001, 5'b0);
    idle(3);
    cyc(1'b1, 5'b00001, 5'b0);
    idle(3);
    chk("hold_b_busy", 32'(b_busy), 1);
    chk("hold_b_drv", 32'(b_drv), 0);
    cyc(1'b0, 5'b0, 5'b00001);
    cyc(1'b0, 5'b0, 5'b0);
    chk("ret_b_drv", 32'(b_drv), 32'h01);
    idle(3);

    // Credit return in the dispatch cycle, then saturation.
    cyc(1'b1, 5'b00010, 5'b0);
    cyc(1'b0, 5'b0, 5'b00010);
    chk("sim_a_cred1", 32'(a_cred[3:2]), 2);
    chk("sim_b_cred1", 32'(b_cred[1]), 1);
    idle(2);
    for (int i = 0; i < 5; i++) cyc(1'b0, 5'b0, 5'b00010);
    chk("sat_a_cred1", 32'(a_cred[3:2]), 2);
    chk("sat_b_cred1", 32'(b_cred[1]), 1);
    cyc(1'b0, 5'b0, 5'b11111);
    cyc(1'b0, 5'b0, 5'b11111);

    // Multicast blocked on channel 4 until its credit returns.
    cyc(1'b1, 5'b10000, 5'b0);
    idle(3);
    cyc(1'b1, 5'b10011, 5'b0);
    idle(3);
    chk("mc_b_busy", 32'(b_busy), 1);
    chk("mc_b_drv", 32'(b_drv), 0);
    cyc(1'b0, 5'b0, 5'b10000);
    cyc(1'b0, 5'b0, 5'b0);
    chk("mc_b_drv_all", 32'(b_drv), 32'h13);
    cyc(1'b0, 5'b0, 5'b0);
    chk("mc_b_free", 32'(b_free), 1);
    idle(2);

    // Unicast lowest bit, zero mask, drive while held.
    cyc(1'b1, 5'b01010, 5'b0);
    cyc(1'b0, 5'b0, 5'b0);
    chk("uc_a_drv", 32'(a_drv), 32'h02);
    idle(3);
    cyc(1'b1, 5'b00000, 5'b0);
    cyc(1'b0, 5'b0, 5'b0);
    chk("zero_a_drv", 32'(a_drv), 0);
    cyc(1'b0, 5'b0, 5'b0);
    chk("zero_a_free", 32'(a_free), 1);
    idle(1);
    cyc(1'b1, 5'b00001, 5'b0);
    cyc(1'b1, 5'b00010, 5'b0);
    idle(4);

    // Reset while the multicast instance holds a token.
    cyc(1'b1, 5'b01000, 5'b0);
    cyc(1'b0, 5'b0, 5'b0);
    chk("pre_rst_b_busy", 32'(b_busy), 1);
    do_reset();
    first_token();
    idle(2);

    for (int i = 0; i < 400; i++) begin
      logic       d;
      logic [4:0] v, f;
      d = ($urandom_range(0, 2) == 0);
      v = 5'($urandom);
      for (int k = 0; k < 5; k++) f[k] = ($urandom_range(0, 4) == 0);
      cyc(d, v, f);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
